ula_seq: RTL
============

// Module: ula_seq
// PURPOSE
//  Operation sequencer driving the ULA operand/opcode side. Accepts one instruction per
//  valid/ready handshake, reads operands from an internal register file, presents A/B/OP to the
//  ULA, captures RESU and O/C/S/Z, then writes the result back and latches the flags.
//  Sits between instruction fetch/decode and the ULA; sole producer of ULA A, B and OP.
// PARAMETERS
//  WIDTH  3  data width; equals ULA A/B/RESU width
//  OPW    5  opcode width; equals ULA OP width
//  NREG   8  register file entries; address width AW = $clog2(NREG) = 3
// PORTS
//  CLK       in   1      clock; all state changes on rising edge
//  RST       in   1      synchronous reset, active high
//  IN_VALID  in   1      instruction present
//  IN_READY  out  1      sequencer accepts instruction this cycle
//  IN_OP     in   OPW    ULA opcode
//  IN_RD     in   AW     destination register
//  IN_RA     in   AW     operand A register
//  IN_RB     in   AW     operand B register
//  IN_LOAD   in   1      1: write IN_IMM to RD, bypass ULA
//  IN_IMM    in   WIDTH  immediate for IN_LOAD
//  IN_NOWB   in   1      1: compare-style op, flags updated, no register write
//  A, B      out  WIDTH  ULA operands (registered)
//  OP        out  OPW    ULA opcode (registered)
//  RESU      in   WIDTH  ULA result
//  O,C,S,Z   in   1      ULA flags
//  FLAGS     out  4      latched {O,C,S,Z}
//  WB_VALID  out  1      one-cycle pulse: register written
//  WB_ADDR   out  AW     register written
//  WB_DATA   out  WIDTH  value written
//  DONE      out  1      one-cycle pulse per retired instruction (incl. LOAD/NOWB)
//  DBG_ADDR  in   AW     debug read address
//  DBG_DATA  out  WIDTH  regs[DBG_ADDR], combinational read
// BEHAVIOUR
//  - Reset (RST=1 at edge): state IDLE; all regs, A, B, OP, FLAGS, WB_ADDR, WB_DATA = 0;
//    WB_VALID = DONE = 0; IN_READY = 1 in the cycle after. In-flight instruction dropped:
//    no writeback, no DONE, flags untouched by it.
//  - FSM: IDLE -> ISSUE -> RETIRE -> IDLE. IN_READY = 1 only in IDLE (combinational on state).
//  - IDLE: on IN_VALID & IN_READY at edge t, latch instruction fields; A <= regs[RA],
//    B <= regs[RB], OP <= IN_OP; go to ISSUE. IN_VALID without IN_READY: ignored, no change.
//  - ISSUE (cycle t+1): A/B/OP stable for the whole cycle; the ULA settles combinationally.
//    At edge t+1:
//      LOAD:   regs[RD] <= IMM; FLAGS unchanged.
//      NOWB:   FLAGS <= {O,C,S,Z}; regs unchanged.
//      normal: regs[RD] <= RESU; FLAGS <= {O,C,S,Z}.
//    WB_ADDR/WB_DATA <= written addr/value (held until next write); go to RETIRE.
//  - RETIRE (cycle t+2): DONE = 1; WB_VALID = 1 unless NOWB. Go to IDLE at edge t+2.
//  - Throughput: one instruction per 3 cycles; next accept earliest at edge t+3.
//    No hazards: writeback completes before next operand read.
//  - A, B, OP hold their last values outside ISSUE (no toggling in IDLE).
//  - RD == RA or RB: operands read before write; result replaces source, per ordinary semantics.
//  - DBG_DATA reflects a write from the cycle after the writing edge (no bypass).
//  - Widths: RESU and IMM are WIDTH bits; no sign/zero extension anywhere; overflow/carry
//    detection is the ULA's, captured verbatim.
//  - IN_* fields are sampled only at the accepting edge; later changes have no effect.
// TESTING
//  1 Reset: RST high 2 cycles -> FLAGS=0, WB_VALID=0, DONE=0, IN_READY=1, DBG_DATA=0 for all regs.
//  2 LOAD r1=3, LOAD r2=5 -> WB pulses (1,3), (2,5); DONE 2 cycles after each accept; FLAGS stay 0.
//  3 ULA add r3=r1+r2 -> A=3, B=5 during ISSUE; r3=0 (3-bit wrap); FLAGS per ULA (C=1, Z=1).
//  4 NOWB compare r1,r2 -> FLAGS updated, WB_VALID=0, DONE=1, r1..r3 unchanged.
//  5 IN_VALID held high continuously -> accepts exactly every 3rd cycle; IN_READY=0 in ISSUE/RETIRE.
//  6 RST asserted during ISSUE of add into r4 -> r4 stays 0, no WB_VALID/DONE, IDLE next cycle.

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq: operation sequencer for the ULA. It accepts one instruction per valid/ready
// handshake and reads the operands from an internal register file. It drives registered
// A/B/OP, captures RESU and the O/C/S/Z flags one cycle later, then writes the result back.
// Each instruction takes three cycles: IDLE (accept) -> ISSUE (ULA settles) -> RETIRE (pulses).
module ula_seq #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned OPW   = 5,
  parameter int unsigned NREG  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  // Instruction handshake
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [OPW-1:0]           in_op_i,
  input  logic [$clog2(NREG)-1:0]  in_rd_i,
  input  logic [$clog2(NREG)-1:0]  in_ra_i,
  input  logic [$clog2(NREG)-1:0]  in_rb_i,
  input  logic                     in_load_i,
  input  logic [WIDTH-1:0]         in_imm_i,
  input  logic                     in_nowb_i,
  // ULA side
  output logic [WIDTH-1:0]         a_o,
  output logic [WIDTH-1:0]         b_o,
  output logic [OPW-1:0]           op_o,
  input  logic [WIDTH-1:0]         resu_i,
  input  logic                     o_i,
  input  logic                     c_i,
  input  logic                     s_i,
  input  logic                     z_i,
  // Status and writeback
  output logic [3:0]               flags_o,
  output logic                     wb_valid_o,
  output logic [$clog2(NREG)-1:0]  wb_addr_o,
  output logic [WIDTH-1:0]         wb_data_o,
  output logic                     done_o,
  // Debug read port
  input  logic [$clog2(NREG)-1:0]  dbg_addr_i,
  output logic [WIDTH-1:0]         dbg_data_o
);

  localparam int unsigned AW = $clog2(NREG);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StRetire = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Instruction fields captured at the accepting edge
  logic [AW-1:0]    rd_q, rd_d;
  logic             load_q, load_d;
  logic             nowb_q, nowb_d;
  logic [WIDTH-1:0] imm_q, imm_d;

  // Operand/opcode registers feeding the ULA
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;

  // Architectural state
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic [3:0]       flags_q, flags_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  // Next-state logic: accept in IDLE, write back at the end of ISSUE, retire after that
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    load_d    = load_q;
    nowb_d    = nowb_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    regs_d    = regs_q;
    flags_d   = flags_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          rd_d    = in_rd_i;
          load_d  = in_load_i;
          nowb_d  = in_nowb_i;
          imm_d   = in_imm_i;
          a_d     = regs_q[in_ra_i];
          b_d     = regs_q[in_rb_i];
          op_d    = in_op_i;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // LOAD takes priority over NOWB when both are set
        if (load_q) begin
          regs_d[rd_q] = imm_q;
          wb_addr_d    = rd_q;
          wb_data_d    = imm_q;
        end else if (nowb_q) begin
          flags_d = {o_i, c_i, s_i, z_i};
        end else begin
          regs_d[rd_q] = resu_i;
          flags_d      = {o_i, c_i, s_i, z_i};
          wb_addr_d    = rd_q;
          wb_data_d    = resu_i;
        end
        state_d = StRetire;
      end
      StRetire: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight instruction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      load_q    <= 1'b0;
      nowb_q    <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      flags_q   <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      load_q    <= load_d;
      nowb_q    <= nowb_d;
      imm_q     <= imm_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      flags_q   <= flags_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    in_ready_o = (state_q == StIdle);
    done_o     = (state_q == StRetire);
    wb_valid_o = (state_q == StRetire) && !nowb_q;
    a_o        = a_q;
    b_o        = b_q;
    op_o       = op_q;
    flags_o    = flags_q;
    wb_addr_o  = wb_addr_q;
    wb_data_o  = wb_data_q;
    dbg_data_o = regs_q[dbg_addr_i];
  end

endmodule
